// File: rtl/output_display_driver_if.sv
// output_display_driver_if: value/mode into the display driver, BCD result and 7-segment scan out.
interface output_display_driver_if;
  logic [7:0]  value;
  logic        signed_mode;
  logic [11:0] bcd;
  logic        neg;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  modport master(output value, signed_mode, input bcd, neg, busy, seg, an);
  modport slave(input value, signed_mode, output bcd, neg, busy, seg, an);
endinterface

// File: rtl/output_display_driver.sv
// output_display_driver: double-dabble binary to BCD with optional sign, multiplexed onto a
// 4-digit common-anode 7-segment display.
module output_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input logic                      clk,
  input logic                      clear,
  output_display_driver_if.slave   bus
);
  localparam int PW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t      state;
  logic [8:0]  key;
  logic [19:0] sh;
  logic [19:0] adj;
  logic [2:0]  cnt;
  logic [11:0] bcd_r;
  logic        neg_r;
  logic        busy_r;
  logic [7:0]  mag;
  logic [PW-1:0] presc;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        blank;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  endfunction
  assign mag = (bus.signed_mode & bus.value[7]) ? 8'(~bus.value + 8'd1) : bus.value;
  assign adj = {add3(sh[19:16]), add3(sh[15:12]), add3(sh[11:8]), sh[7:0]};
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      key    <= 9'h000;
      sh     <= 20'h0;
      cnt    <= 3'd0;
      bcd_r  <= 12'h000;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if ({bus.signed_mode, bus.value} != key) begin
          key    <= {bus.signed_mode, bus.value};
          sh     <= {12'h000, mag};
          cnt    <= 3'd0;
          busy_r <= 1'b1;
          state  <= SHIFT;
        end
        SHIFT: begin
          sh    <= {adj[18:0], 1'b0};
          cnt   <= cnt + 3'd1;
          state <= (cnt == 3'd7) ? COMMIT : SHIFT;
        end
        default: begin
          bcd_r  <= sh[19:8];
          neg_r  <= key[8] & key[7];
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end
  // Leading-zero blanking: tens only blanks when hundreds is also zero.
  always_comb begin
    nib   = (idx == 2'd0) ? bcd_r[3:0] : (idx == 2'd1) ? bcd_r[7:4] : bcd_r[11:8];
    blank = (idx == 2'd2 && bcd_r[11:8] == 4'd0) ||
            (idx == 2'd1 && bcd_r[11:4] == 8'd0);
    bus.seg = (idx == 2'd3) ? (neg_r ? 7'b0111111 : 7'b1111111) :
              blank ? 7'b1111111 : dec(nib);
  end
  assign bus.an   = ~(4'b0001 << idx);
  assign bus.bcd  = bcd_r;
  assign bus.neg  = neg_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_output_display_driver.sv
// tb_output_display_driver: table-driven conversion/scan vectors plus hand-written
// reset, mid-conversion and steady-input sequences.
module tb_output_display_driver;
  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;
  output_display_driver_if bus();
  output_display_driver #(.SCAN_DIV(4)) dut (.clk(clk), .clear(clear), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0]       value;
    logic             sm;
    logic [11:0]      bcd;
    logic             neg;
    logic [3:0][6:0]  segs;
  } vec_t;
  vec_t vec [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction
  task automatic convert(input logic [7:0] v, input logic sm, input logic [11:0] eb,
                         input logic en, input logic [11:0] old_bcd);
    int nb;
    nb = 0;
    @(negedge clk);
    clear = 1'b0;
    bus.value = v;
    bus.signed_mode = sm;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      nb += int'(bus.busy);
      if (i == 9) chk("bcd_before_commit", 32'(bus.bcd), 32'(old_bcd));
    end
    chk("busy_cycles", nb, 9);
    chk("bcd", 32'(bus.bcd), 32'(eb));
    chk("neg", 32'(bus.neg), 32'(en));
    chk("busy_after", 32'(bus.busy), 0);
  endtask
  task automatic scan(input logic [3:0][6:0] es);
    logic [3:0] p;
    int n;
    int k;
    p = bus.an;
    n = 0;
    while (bus.an == p && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("scan_sync", 32'(bus.an != p), 1);
    for (int d = 0; d < 4; d++) begin
      p = bus.an;
      k = idx_of(p);
      chk("an_onehot", 32'(k >= 0), 1);
      if (k >= 0) chk($sformatf("seg_digit%0d", k), 32'(bus.seg), 32'(es[k]));
      n = 0;
      while (bus.an == p && n < 8) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("dwell", n, 4);
      chk("an_next", 32'(bus.an), 32'({p[2:0], p[3]}));
    end
  endtask
  initial begin
    int nb;
    logic [11:0] cur;
    vec[0]  = '{8'd123, 1'b0, 12'h123, 1'b0, {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000}};
    vec[1]  = '{8'd7,   1'b0, 12'h007, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
    vec[2]  = '{8'hFF,  1'b1, 12'h001, 1'b1, {7'b0111111, 7'b1111111, 7'b1111111, 7'b1111001}};
    vec[3]  = '{8'h80,  1'b1, 12'h128, 1'b1, {7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000}};
    vec[4]  = '{8'h80,  1'b0, 12'h128, 1'b0, {7'b1111111, 7'b1111001, 7'b0100100, 7'b0000000}};
    vec[5]  = '{8'h81,  1'b1, 12'h127, 1'b1, {7'b0111111, 7'b1111001, 7'b0100100, 7'b1111000}};
    vec[6]  = '{8'd10,  1'b0, 12'h010, 1'b0, {7'b1111111, 7'b1111111, 7'b1111001, 7'b1000000}};
    vec[7]  = '{8'd65,  1'b1, 12'h065, 1'b0, {7'b1111111, 7'b1111111, 7'b0000010, 7'b0010010}};
    vec[8]  = '{8'h9C,  1'b1, 12'h100, 1'b1, {7'b0111111, 7'b1111001, 7'b1000000, 7'b1000000}};
    vec[9]  = '{8'hF6,  1'b1, 12'h010, 1'b1, {7'b0111111, 7'b1111111, 7'b1111001, 7'b1000000}};
    vec[10] = '{8'h04,  1'b1, 12'h004, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0011001}};
    vec[11] = '{8'hFF,  1'b0, 12'h255, 1'b0, {7'b1111111, 7'b0100100, 7'b0010010, 7'b0010010}};
    bus.value = 8'd0;
    bus.signed_mode = 1'b0;
    #2 clear = 1'b1;
    #1;
    chk("rst_bcd", 32'(bus.bcd), 0);
    chk("rst_neg", 32'(bus.neg), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_an", 32'(bus.an), 32'(4'b1110));
    chk("rst_seg", 32'(bus.seg), 32'(7'b1000000));
    @(negedge clk);
    clear = 1'b0;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      nb += int'(bus.busy);
    end
    chk("zero_after_reset_no_busy", nb, 0);
    cur = 12'h000;
    for (int i = 0; i < 12; i++) begin
      convert(vec[i].value, vec[i].sm, vec[i].bcd, vec[i].neg, cur);
      cur = vec[i].bcd;
      scan(vec[i].segs);
    end
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      nb += int'(bus.busy);
    end
    chk("steady_no_busy", nb, 0);
    chk("steady_bcd", 32'(bus.bcd), 32'(cur));
    @(negedge clk);
    bus.value = 8'd200;
    bus.signed_mode = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 9)  chk("mid_busy9", 32'(bus.busy), 1);
      if (i == 10) chk("mid_busy10", 32'(bus.busy), 0);
      if (i == 10) chk("mid_bcd200", 32'(bus.bcd), 32'h200);
      if (i == 11) chk("mid_busy11", 32'(bus.busy), 1);
      if (i == 19) chk("mid_bcd_hold", 32'(bus.bcd), 32'h200);
      if (i == 20) chk("mid_bcd045", 32'(bus.bcd), 32'h045);
      if (i == 20) chk("mid_busy20", 32'(bus.busy), 0);
      if (i == 3) begin
        @(negedge clk);
        bus.value = 8'd45;
      end
    end
    @(negedge clk);
    bus.value = 8'd255;
    repeat (4) @(posedge clk);
    #2 clear = 1'b1;
    #1;
    chk("midrst_bcd", 32'(bus.bcd), 0);
    chk("midrst_neg", 32'(bus.neg), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_an", 32'(bus.an), 32'(4'b1110));
    chk("midrst_seg", 32'(bus.seg), 32'(7'b1000000));
    convert(8'd255, 1'b0, 12'h255, 1'b0, 12'h000);
    scan(vec[11].segs);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/output_display_driver.md
Name: output_display_driver

Overview:
- Downstream consumer of the 8-bit output register value, sitting between `out` and the board's 4-digit common-anode 7-segment display.
- Converts the binary value to 3 BCD digits using an iterative double-dabble FSM, one shift per clock.
- Optionally interprets the value as two's complement and shows a sign digit.
- Time-multiplexes the 4 digits with a programmable scan prescaler.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is held active; legal range 2..2^20.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  reset; asynchronous, active-high.
- value  input  8  binary value from the output register.
- signed_mode  input  1  1 = value is two's complement; 0 = unsigned.
- bcd  output  12  committed BCD magnitude {hundreds, tens, ones}.
- neg  output  1  committed sign flag; 1 only when signed_mode=1 and value[7]=1.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- an  output  4  active-low one-hot digit enable; an[0] = ones (rightmost), an[3] = sign.

Behaviour:
- Reset (async, clear=1):
  - FSM goes to IDLE.
  - bcd=12'h000, neg=0, busy=0.
  - Latched key {signed_mode,value} = 9'h000.
  - Prescaler=0, digit index=0, so an=4'b1110 and seg=7'b1000000 ('0').
- FSM states are IDLE, SHIFT, COMMIT.
- IDLE:
  - If {signed_mode,value} != latched key, latch the key and compute the magnitude.
  - Magnitude = (signed_mode & value[7]) ? (~value+1) as 9-bit : value. Value 8'h80 signed therefore gives 128.
  - Load the shift register {12'h000, mag[7:0]}, set count=0, busy=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1 and increment count.
  - After the 8th shift (count==7 this cycle), go to COMMIT.
- COMMIT:
  - bcd <= the BCD field, neg <= latched sign, busy <= 0, go to IDLE.
- Latency: input change to bcd/neg update = 10 clocks (1 IDLE + 8 SHIFT + 1 COMMIT). busy is high for exactly 9 clocks.
- Input change during SHIFT/COMMIT: the in-flight conversion completes with the old key and the old result is committed. The IDLE cycle then detects the mismatch and reconverts; the worst case is 20 clocks to the final value.
- Input steady at the latched key: no conversion starts and busy stays 0.
- Reset mid-conversion: the result is discarded and all outputs return to their reset values.
- Because the reset key is 0 and the display reset is "0", no conversion occurs after reset if value=0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
  - an = ~(4'b0001 << index).
  - seg is combinational from the registered index, bcd and neg.
- Digit decode:
  - Digits 0-9 use standard patterns; for example '1' = 7'b1111001, '2' = 7'b0100100, '3' = 7'b0110000.
  - Blank = 7'b1111111.
  - Minus = 7'b0111111 (g only).
- Leading-zero blanking:
  - Hundreds is blank if 0.
  - Tens is blank if hundreds==0 and tens==0.
  - Ones is always shown.
  - The sign digit shows minus if neg, else blank.
- Values reaching the BCD logic are never > 255, so nibbles > 9 cannot occur. If one does, the decoder shows blank.

Test Plan:
- Reset: assert clear mid-cycle with value=0 → bcd=000, neg=0, busy=0, an=1110, seg=1000000, with no clock required.
- Unsigned: value=8'd123, signed_mode=0 → busy high 9 clocks; bcd=12'h123 exactly 10 clocks after the change.
- Blanking/scan: SCAN_DIV=4, value=8'd7 → an cycles 1110,1101,1011,0111, changing every 4 clocks. seg is '7'(1111000) on digit 0 and blank on digits 1-3.
- Signed: signed_mode=1, value=8'hFF → neg=1, bcd=001, sign digit shows 0111111. With value=8'h80 → bcd=128, neg=1. Toggling signed_mode alone with value=8'h80 → reconversion, bcd=128, neg=0.
- Mid-conversion change: value 8'd200 then 8'd45 three clocks later → bcd=200 commits first, then bcd=045 no later than 20 clocks after the first change. busy drops for exactly 1 clock between the two conversions.
- Reset mid-conversion: value=8'd255, clear pulsed during SHIFT → outputs return to reset values. After release, conversion restarts and bcd=255 10 clocks later.
